// File: rtl/half_duplex_dir_ctrl.sv
// half_duplex_dir_ctrl
// Direction controller for a single-wire half-duplex link between a sender
// and a reciever port. Arbitrates requests from both ends, drives the buffer
// direction select and output enable, inserts TURN_CYCLES dead cycles on
// every direction change and limits bursts to MAX_BURST granted cycles when
// the opposite side is waiting. The 1-bit payload is carried registered.
//
// Optional feature macro: HDX_COLLISION_DET_EN
//   defined   : err is a sticky flag set when the non-owning side drives a 1
//               while the line is granted to the other side.
//   undefined : err is tied low and no detection logic exists.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | nobody owns the line, drive_en low, dir holds its last value
// S2R   | sender owns the line, dir=1, drive_en=1, sender_grant=1
// TURN  | dead time before the target side gets the line, dir=target
// R2S   | reciever owns the line, dir=0, drive_en=1, reciever_grant=1

module half_duplex_dir_ctrl #(
   parameter int TURN_CYCLES = 2,
   parameter int MAX_BURST   = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic sender_req,
   input  logic reciever_req,
   input  logic sender_in,
   input  logic reciever_in,
   output logic dir,
   output logic drive_en,
   output logic sender_grant,
   output logic reciever_grant,
   output logic sender_out,
   output logic reciever_out,
   output logic err
);

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int TW = $clog2(TURN_CYCLES + 1);

   // Counters run from 0 on entry; the last value is one below the limit so
   // the count of cycles spent equals the limit when the decision is taken.
   localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
   localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_CYCLES - 1);
   localparam logic [BW-1:0] BURST_ONE  = BW'(1);
   localparam logic [TW-1:0] TURN_ONE   = TW'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_S2R  = 2'd1,
      ST_TURN = 2'd2,
      ST_R2S  = 2'd3
   } state_t;

   state_t        state_q,    state_d;
   logic [BW-1:0] burst_q,    burst_d;
   logic [TW-1:0] turn_q,     turn_d;
   logic          tgt_snd_q,  tgt_snd_d;   // TURN target: 1 = sender side
   logic          last_snd_q, last_snd_d;  // last served: 1 = sender side
   logic          dir_q,      dir_d;
   logic          drive_en_q, drive_en_d;
   logic          s_grant_q,  s_grant_d;
   logic          r_grant_q,  r_grant_d;
   logic          s_out_q,    s_out_d;
   logic          r_out_q,    r_out_d;

   logic          any_req;
   logic          want_snd;
   logic          tgt_req;

   // Arbitration helpers: which side would win a request seen in IDLE, and
   // whether the TURN target still wants the line.
   always_comb begin
      any_req  = sender_req | reciever_req;
      want_snd = 1'b0;
      if (sender_req && reciever_req) begin
         want_snd = ~last_snd_q;
      end else begin
         want_snd = sender_req;
      end
      tgt_req = tgt_snd_q ? sender_req : reciever_req;
   end

   // Next-state, counter and bookkeeping logic.
   always_comb begin
      state_d    = state_q;
      burst_d    = burst_q;
      turn_d     = turn_q;
      tgt_snd_d  = tgt_snd_q;
      last_snd_d = last_snd_q;

      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               if (want_snd == dir_q) begin
                  state_d    = want_snd ? ST_S2R : ST_R2S;
                  burst_d    = '0;
                  last_snd_d = want_snd;
               end else begin
                  state_d   = ST_TURN;
                  tgt_snd_d = want_snd;
                  turn_d    = '0;
               end
            end
         end

         ST_S2R: begin
            if (!sender_req) begin
               state_d = ST_IDLE;
               burst_d = '0;
            end else if (burst_q == BURST_LAST) begin
               burst_d = '0;
               if (reciever_req) begin
                  state_d   = ST_TURN;
                  tgt_snd_d = 1'b0;
                  turn_d    = '0;
               end
            end else begin
               burst_d = burst_q + BURST_ONE;
            end
         end

         ST_R2S: begin
            if (!reciever_req) begin
               state_d = ST_IDLE;
               burst_d = '0;
            end else if (burst_q == BURST_LAST) begin
               burst_d = '0;
               if (sender_req) begin
                  state_d   = ST_TURN;
                  tgt_snd_d = 1'b1;
                  turn_d    = '0;
               end
            end else begin
               burst_d = burst_q + BURST_ONE;
            end
         end

         ST_TURN: begin
            if (turn_q == TURN_LAST) begin
               turn_d = '0;
               if (tgt_req) begin
                  state_d    = tgt_snd_q ? ST_S2R : ST_R2S;
                  burst_d    = '0;
                  last_snd_d = tgt_snd_q;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               turn_d = turn_q + TURN_ONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            burst_d = '0;
            turn_d  = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they register in step with
   // the state; the payload uses the current state so it lags by one cycle.
   always_comb begin
      dir_d      = dir_q;
      drive_en_d = 1'b0;
      s_grant_d  = 1'b0;
      r_grant_d  = 1'b0;
      unique case (state_d)
         ST_S2R: begin
            dir_d      = 1'b1;
            drive_en_d = 1'b1;
            s_grant_d  = 1'b1;
         end
         ST_R2S: begin
            dir_d      = 1'b0;
            drive_en_d = 1'b1;
            r_grant_d  = 1'b1;
         end
         ST_TURN: begin
            dir_d = tgt_snd_d;
         end
         default: begin
            dir_d = dir_q;
         end
      endcase
      r_out_d = (state_q == ST_S2R) ? sender_in   : 1'b0;
      s_out_d = (state_q == ST_R2S) ? reciever_in : 1'b0;
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         burst_q    <= '0;
         turn_q     <= '0;
         tgt_snd_q  <= 1'b0;
         last_snd_q <= 1'b0;
         dir_q      <= 1'b0;
         drive_en_q <= 1'b0;
         s_grant_q  <= 1'b0;
         r_grant_q  <= 1'b0;
         s_out_q    <= 1'b0;
         r_out_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         burst_q    <= burst_d;
         turn_q     <= turn_d;
         tgt_snd_q  <= tgt_snd_d;
         last_snd_q <= last_snd_d;
         dir_q      <= dir_d;
         drive_en_q <= drive_en_d;
         s_grant_q  <= s_grant_d;
         r_grant_q  <= r_grant_d;
         s_out_q    <= s_out_d;
         r_out_q    <= r_out_d;
      end
   end

`ifdef HDX_COLLISION_DET_EN
   logic err_q, err_d;

   // Sticky collision flag: the non-owning side drove a 1 during a grant.
   always_comb begin
      err_d = err_q;
      if ((state_q == ST_S2R && reciever_in) || (state_q == ST_R2S && sender_in)) begin
         err_d = 1'b1;
      end
   end

   // Collision flag register, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign dir            = dir_q;
   assign drive_en       = drive_en_q;
   assign sender_grant   = s_grant_q;
   assign reciever_grant = r_grant_q;
   assign sender_out     = s_out_q;
   assign reciever_out   = r_out_q;

endmodule

// File: tb/tb_half_duplex_dir_ctrl.sv
// tb_half_duplex_dir_ctrl
// Directed scenarios followed by randomized request/payload traffic, checked
// every cycle against a cycle-level reference model of the link ownership.
// Honours HDX_COLLISION_DET_EN for the expected err behaviour.

module tb_half_duplex_dir_ctrl;

   localparam int TURN_CYCLES = 2;
   localparam int MAX_BURST   = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic sender_req = 1'b0, reciever_req = 1'b0;
   logic sender_in = 1'b0, reciever_in = 1'b0;
   logic dir, drive_en, sender_grant, reciever_grant;
   logic sender_out, reciever_out, err;

   int n_vec  = 0;
   int n_fail = 0;

   half_duplex_dir_ctrl #(.TURN_CYCLES(TURN_CYCLES), .MAX_BURST(MAX_BURST)) dut (
      .clk            (clk),
      .rst            (rst),
      .sender_req     (sender_req),
      .reciever_req   (reciever_req),
      .sender_in      (sender_in),
      .reciever_in    (reciever_in),
      .dir            (dir),
      .drive_en       (drive_en),
      .sender_grant   (sender_grant),
      .reciever_grant (reciever_grant),
      .sender_out     (sender_out),
      .reciever_out   (reciever_out),
      .err            (err)
   );

   always #5 clk = ~clk;

   // Reference model: owner 0 = nobody, 1 = sender, 2 = reciever.
   // turn_left counts remaining dead cycles; owner is 0 while turning.
   int m_owner, m_turn_left, m_target, m_granted;
   int m_dir, m_last_snd, m_err, m_so, m_ro;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = 0; m_turn_left = 0; m_target = 0; m_granted = 0;
      m_dir = 0; m_last_snd = 0; m_err = 0; m_so = 0; m_ro = 0;
   endtask

   task automatic model_grant(input int w);
      m_owner    = w;
      m_granted  = 0;
      m_last_snd = (w == 1) ? 1 : 0;
      m_dir      = (w == 1) ? 1 : 0;
   endtask

   task automatic model_turn(input int w);
      m_owner     = 0;
      m_dir       = (w == 1) ? 1 : 0;
      m_turn_left = TURN_CYCLES;
      m_target    = w;
   endtask

   task automatic model_step();
      int sr, rr, w, mine, other;
      sr = int'(sender_req);
      rr = int'(reciever_req);
      m_ro = (m_owner == 1) ? int'(sender_in)   : 0;
      m_so = (m_owner == 2) ? int'(reciever_in) : 0;
`ifdef HDX_COLLISION_DET_EN
      if ((m_owner == 1 && reciever_in) || (m_owner == 2 && sender_in)) m_err = 1;
`endif
      if (m_turn_left > 0) begin
         m_turn_left--;
         if (m_turn_left == 0) begin
            if ((m_target == 1) ? sr : rr) model_grant(m_target);
         end
      end else if (m_owner == 0) begin
         if (sr || rr) begin
            if (sr && rr) w = m_last_snd ? 2 : 1;
            else          w = sr ? 1 : 2;
            if (((w == 1) ? 1 : 0) == m_dir) model_grant(w);
            else                             model_turn(w);
         end
      end else begin
         m_granted++;
         mine  = (m_owner == 1) ? sr : rr;
         other = (m_owner == 1) ? rr : sr;
         if (!mine) m_owner = 0;
         else if ((m_granted % MAX_BURST) == 0 && other) model_turn(3 - m_owner);
      end
   endtask

   task automatic check_all();
      chk("dir",            int'(dir),            m_dir);
      chk("drive_en",       int'(drive_en),       (m_owner != 0) ? 1 : 0);
      chk("sender_grant",   int'(sender_grant),   (m_owner == 1) ? 1 : 0);
      chk("reciever_grant", int'(reciever_grant), (m_owner == 2) ? 1 : 0);
      chk("reciever_out",   int'(reciever_out),   m_ro);
      chk("sender_out",     int'(sender_out),     m_so);
      chk("err",            int'(err),            m_err);
   endtask

   // One clock: model consumes the inputs seen at the edge, DUT is checked
   // shortly after; the caller then changes inputs well away from any edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      #2;
      check_all();
   endtask

   // Asynchronous reset: outputs must clear without waiting for a clock.
   task automatic apply_reset();
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_dir",      int'(dir),            0);
      chk("rst_drive_en", int'(drive_en),       0);
      chk("rst_sgrant",   int'(sender_grant),   0);
      chk("rst_rgrant",   int'(reciever_grant), 0);
      chk("rst_sout",     int'(sender_out),     0);
      chk("rst_rout",     int'(reciever_out),   0);
      chk("rst_err",      int'(err),            0);
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      int cnt;
      model_reset();
      @(negedge clk);
      apply_reset();

      // Sender request with dir=0: two dead cycles, then grant.
      sender_req = 1'b1;
      tick();
      chk("turn1_dir", int'(dir), 1);
      chk("turn1_de",  int'(drive_en), 0);
      tick();
      chk("turn2_de",  int'(drive_en), 0);
      tick();
      chk("s_grant_latency", int'(sender_grant), 1);
      chk("s_grant_de",      int'(drive_en), 1);
      sender_in = 1'b1;
      tick();
      chk("payload_lat", int'(reciever_out), 1);
      sender_in = 1'b0;

      // Reciever waits: sender keeps the line for exactly MAX_BURST cycles.
      reciever_req = 1'b1;
      cnt = 2;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (!sender_grant) break;
         cnt++;
      end
      chk("burst_len", cnt, MAX_BURST);
      chk("preempt_dir", int'(dir), 0);
      cnt = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (reciever_grant) break;
         cnt++;
      end
      chk("dead_cycles", cnt, TURN_CYCLES);

      // Target drops during TURN: back to IDLE with no grant.
      sender_req = 1'b0; reciever_req = 1'b0;
      tick();
      sender_req = 1'b1;
      tick();
      sender_req = 1'b0;
      tick();
      tick();
      tick();
      chk("drop_sgrant", int'(sender_grant), 0);
      chk("drop_de",     int'(drive_en), 0);

      // Tie from IDLE with dir=1, sender served last: reciever wins.
      sender_req = 1'b1;
      tick();
      chk("direct_grant", int'(sender_grant), 1);
      sender_req = 1'b0;
      tick();
      sender_req = 1'b1; reciever_req = 1'b1;
      tick();
      chk("tie_dir", int'(dir), 0);
      tick();
      tick();
      chk("tie_winner", int'(reciever_grant), 1);
      tick();

      // Reset mid-burst, then a sender request must turn again.
      @(negedge clk);
      apply_reset();
      reciever_req = 1'b0;
      tick();
      chk("post_rst_turn", int'(drive_en), 0);
      tick();
      tick();

      // Randomized traffic with sticky requests.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(5) == 0) sender_req   = ~sender_req;
         if ($urandom_range(5) == 0) reciever_req = ~reciever_req;
         sender_in   = $urandom_range(1) == 1;
         reciever_in = ($urandom_range(7) == 0);
         if ($urandom_range(999) == 0) begin
            @(negedge clk);
            apply_reset();
         end else begin
            tick();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
